// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX issue logic and the multi-cycle mul/div unit.
// The issue side is the master: it drives the operation and accepts the result.
interface ex_muldiv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [XLEN-1:0]       src1;
  logic [XLEN-1:0]       src2;
  logic [REG_ADDR_W-1:0] rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_data;
  logic [REG_ADDR_W-1:0] out_rd;

  modport master (
    output in_valid, op, src1, src2, rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  in_valid, op, src1, src2, rd, out_ready,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: XLEN/BITS_PER_CYCLE+1 edges per op (1 for divide special cases).
// Result is held in DONE until out_ready; no new accept until back in IDLE; flush aborts.
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int REG_ADDR_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  output logic       busy,
  ex_muldiv_if.slave bus
);
  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       acc, lo, opnd, data_q;
  logic                  neg_q;
  logic [CNT_W-1:0]      cnt;

  // Operand conditioning at accept
  logic            is_div, signed1, signed2, s1, s2, div_zero, div_ovf, special, accept, neg_in;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    is_div   = bus.op[2];
    signed1  = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
    signed2  = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    s1       = signed1 & bus.src1[XLEN-1];
    s2       = signed2 & bus.src2[XLEN-1];
    mag1     = s1 ? -bus.src1 : bus.src1;
    mag2     = s2 ? -bus.src2 : bus.src2;
    div_zero = is_div && (bus.src2 == '0);
    div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.src1 == MIN_VAL) && (bus.src2 == '1);
    special  = div_zero || div_ovf;
    neg_in   = (is_div && bus.op[1]) ? s1 : (s1 ^ s2);
    accept   = bus.in_valid && (state == IDLE) && !flush;
  end

  // One iteration step; {acc,lo} is the product for multiply, {remainder,dividend/quotient} for divide
  logic [XLEN-1:0] m_hi, m_lo, d_rem, d_quo;
  logic [XLEN:0]   m_sum, d_trial;

  always_comb begin
    m_hi    = acc;
    m_lo    = lo;
    d_rem   = acc;
    d_quo   = lo;
    m_sum   = '0;
    d_trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      m_sum   = {1'b0, m_hi} + (m_lo[0] ? {1'b0, opnd} : '0);
      m_lo    = {m_sum[0], m_lo[XLEN-1:1]};
      m_hi    = m_sum[XLEN:1];
      d_trial = {d_rem, d_quo[XLEN-1]};
      d_quo   = {d_quo[XLEN-2:0], 1'b0};
      if (d_trial >= {1'b0, opnd}) begin
        d_trial  = d_trial - {1'b0, opnd};
        d_quo[0] = 1'b1;
      end
      d_rem = d_trial[XLEN-1:0];
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_s = neg_q ? -{acc, lo} : {acc, lo};
    case (op_q)
      OP_MUL:                      fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? -lo : lo;
      default:                     fix_res = neg_q ? -acc : acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = special ? FIX : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q <= bus.op;
      rd_q <= bus.rd;
      cnt  <= CNT_W'(ITERS);
      if (special) begin
        // Special cases skip CALC: preload quotient/remainder so FIX selects them unsigned
        neg_q <= 1'b0;
        opnd  <= '0;
        lo    <= div_zero ? '1 : MIN_VAL;
        acc   <= div_zero ? bus.src1 : '0;
      end else begin
        neg_q <= neg_in;
        acc   <= '0;
        lo    <= is_div ? mag1 : mag2;
        opnd  <= is_div ? mag2 : mag1;
      end
    end else if (state == CALC) begin
      acc <= op_q[2] ? d_rem : m_hi;
      lo  <= op_q[2] ? d_quo : m_lo;
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      data_q <= (rd_q == '0) ? '0 : fix_res;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_rd    = rd_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_ex_muldiv;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy, busy4;
  int   n_chk = 0;
  int   n_err = 0;
  int   last_busy;

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bus4 ();

  ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus)
  );
  ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy4), .bus(bus4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_vld(input bit wide);
    return wide ? bus4.out_valid : bus.out_valid;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy4 : busy;
  endfunction

  task automatic drive(input bit wide, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    if (wide) begin
      bus4.in_valid = 1'b1; bus4.op = op; bus4.src1 = a; bus4.src2 = b; bus4.rd = rd;
    end else begin
      bus.in_valid = 1'b1; bus.op = op; bus.src1 = a; bus.src2 = b; bus.rd = rd;
    end
  endtask

  task automatic drop(input bit wide);
    if (wide) bus4.in_valid = 1'b0;
    else      bus.in_valid  = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid, bounded
  task automatic wait_vld(input bit wide, output int lat, output int nbusy);
    lat   = 0;
    nbusy = int'(get_busy(wide));
    while (!get_vld(wide) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      nbusy += int'(get_busy(wide));
    end
  endtask

  task automatic run(input bit wide, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int exp_lat, input string tag);
    int lat, nbusy;
    @(negedge clk);
    drive(wide, op, a, b, rd);
    @(posedge clk); #1;
    drop(wide);
    wait_vld(wide, lat, nbusy);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, wide ? bus4.out_data : bus.out_data, exp);
    check({tag, "_rd"}, {27'b0, wide ? bus4.out_rd : bus.out_rd}, {27'b0, rd});
    @(posedge clk); #1;
    nbusy += int'(get_busy(wide));
    last_busy = nbusy;
    check({tag, "_exit"}, {31'b0, wide ? bus4.in_ready : bus.in_ready}, 32'd1);
  endtask

  initial begin
    int  lat, nbusy;
    bit  ok, seen;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;  bus.op = '0;  bus.src1 = '0;  bus.src2 = '0;  bus.rd = '0;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.op = '0; bus4.src1 = '0; bus4.src2 = '0; bus4.rd = '0;
    bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run(0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, "mul");
    check("mul_busy_cycles", last_busy, 32'd34);
    run(0, MUL, 32'h1234_5678, 32'h10, 5'd1, 32'h2345_6780, 33, "mul_big");
    run(0, MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, "mulh");
    run(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, "mulhu");
    run(0, MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, "mulhsu");
    run(0, DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, "div");
    run(0, REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, "rem");
    run(0, DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 33, "divu");
    run(0, REMU, 32'd100, 32'd7, 5'd9, 32'd2, 33, "remu");
    run(0, DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, "divu_by0");
    run(0, REM, 32'd5, 32'd0, 5'd11, 32'd5, 1, "rem_by0");
    run(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, "div_ovf");
    run(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, "rem_ovf");
    run(0, MUL, 32'd3, 32'd4, 5'd0, 32'd0, 33, "mul_rd0");

    // Backpressure: result held, a pending request waits until DONE exits
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(0, DIVU, 32'd100, 32'd7, 5'd3);
    @(posedge clk); #1;
    drop(0);
    wait_vld(0, lat, nbusy);
    check("bp_data", bus.out_data, 32'd14);
    @(negedge clk);
    drive(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_data !== 32'd14 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    check("bp_hold", {31'b0, ok}, 32'd1);
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_exit_vld", {31'b0, bus.out_valid}, 32'd0);
    check("bp_exit_rdy", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    drop(0);
    check("bp_accept_busy", {31'b0, busy}, 32'd1);
    wait_vld(0, lat, nbusy);
    check("bp_next_lat", lat, 32'd33);
    check("bp_next_data", bus.out_data, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // Flush in the 12th CALC cycle
    @(negedge clk);
    drive(0, MUL, 32'd7, 32'd3, 5'd6);
    @(posedge clk); #1;
    drop(0);
    repeat (11) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {31'b0, seen}, 32'd0);

    // Asynchronous reset mid-CALC, between clock edges
    @(negedge clk);
    drive(0, MUL, 32'd5, 32'd5, 5'd9);
    @(posedge clk); #1;
    drop(0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("arst_out_data", bus.out_data, 32'd0);
    check("arst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run(1, DIVU, 32'd100, 32'd7, 5'd2, 32'd14, 9, "divu_b4");
    run(1, MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 9, "mul_b4");
    run(1, REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 9, "rem_b4");
    run(1, MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 9, "mulh_b4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
